// File: rtl/sixteen_bit.sv
// sixteen_bit: single-cycle ALU with a registered result and carry/shift-out.
// Twenty opcodes cover pass, add/sub, logic and 1-bit shift/rotate.
// Unused opcodes produce zero. All results appear one clock after the inputs.

module sixteen_bit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] y,
    output logic             Cout
);

    localparam int unsigned SUM_W = WIDTH + 1;

    typedef enum logic [4:0] {
        OP_PASS_A = 5'b00000,
        OP_INC    = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_ADC    = 5'b00011,
        OP_SBB    = 5'b00100,
        OP_SUB    = 5'b00101,
        OP_DEC    = 5'b00110,
        OP_PASS_B = 5'b00111,
        OP_AND    = 5'b01000,
        OP_OR     = 5'b01001,
        OP_XOR    = 5'b01010,
        OP_XNOR   = 5'b01011,
        OP_NOT_A  = 5'b01100,
        OP_NAND   = 5'b01101,
        OP_NOR    = 5'b01110,
        OP_SHL    = 5'b01111,
        OP_SHR    = 5'b10000,
        OP_ASR    = 5'b10001,
        OP_ROL    = 5'b10010,
        OP_ROR    = 5'b10011
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [SUM_W-1:0] sum;
    logic [WIDTH-1:0] logic_r;
    logic [WIDTH-1:0] shift_r;
    logic             shift_c;
    logic [WIDTH-1:0] r;
    logic             c;

    assign op = op_e'(select);

    // Pick the second addend and carry-in so one adder serves every arithmetic opcode.
    always_comb begin
        add_x   = a;
        add_y   = '0;
        add_cin = 1'b0;
        case (op)
            OP_INC: begin
                add_cin = 1'b1;
            end
            OP_ADD: begin
                add_y = b;
            end
            OP_ADC: begin
                add_y   = b;
                add_cin = Cin;
            end
            OP_SBB: begin
                add_y = ~b;
            end
            OP_SUB: begin
                add_y   = ~b;
                add_cin = 1'b1;
            end
            OP_DEC: begin
                add_y = '1;
            end
            default: begin
            end
        endcase
    end

    // Full-width adder; the top bit is the carry (for subtraction, 1 means no borrow).
    assign sum = SUM_W'(add_x) + SUM_W'(add_y) + SUM_W'(add_cin);

    // Bitwise logic unit.
    always_comb begin
        logic_r = '0;
        case (op)
            OP_AND:   logic_r = a & b;
            OP_OR:    logic_r = a | b;
            OP_XOR:   logic_r = a ^ b;
            OP_XNOR:  logic_r = ~(a ^ b);
            OP_NOT_A: logic_r = ~a;
            OP_NAND:  logic_r = ~(a & b);
            OP_NOR:   logic_r = ~(a | b);
            default:  logic_r = '0;
        endcase
    end

    // One-bit shifter/rotator; the bit shifted out becomes the carry.
    always_comb begin
        shift_r = '0;
        shift_c = 1'b0;
        case (op)
            OP_SHL: begin
                shift_r = {a[WIDTH-2:0], 1'b0};
                shift_c = a[WIDTH-1];
            end
            OP_SHR: begin
                shift_r = {1'b0, a[WIDTH-1:1]};
                shift_c = a[0];
            end
            OP_ASR: begin
                shift_r = {a[WIDTH-1], a[WIDTH-1:1]};
                shift_c = a[0];
            end
            OP_ROL: begin
                shift_r = {a[WIDTH-2:0], a[WIDTH-1]};
                shift_c = a[WIDTH-1];
            end
            OP_ROR: begin
                shift_r = {a[0], a[WIDTH-1:1]};
                shift_c = a[0];
            end
            default: begin
                shift_r = '0;
                shift_c = 1'b0;
            end
        endcase
    end

    // Result mux: route the unit that owns the opcode; unused opcodes give zero.
    always_comb begin
        r = '0;
        c = 1'b0;
        case (op)
            OP_PASS_A: r = a;
            OP_PASS_B: r = b;
            OP_INC, OP_ADD, OP_ADC, OP_SBB, OP_SUB, OP_DEC: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
            end
            OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NOT_A, OP_NAND, OP_NOR: begin
                r = logic_r;
            end
            OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
                r = shift_r;
                c = shift_c;
            end
            default: begin
                r = '0;
                c = 1'b0;
            end
        endcase
    end

    // Output register; reset clears the result at once and drops any pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y    <= '0;
            Cout <= 1'b0;
        end else begin
            y    <= r;
            Cout <= c;
        end
    end

endmodule

// File: tb/tb_sixteen_bit.sv
// Directed bench for sixteen_bit: reset, opcode sweep, carry, shifts, latency.

module tb_sixteen_bit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  select;
    logic [15:0] a;
    logic [15:0] b;
    logic        Cin;
    logic [15:0] y;
    logic        Cout;

    int checks = 0;
    int errors = 0;

    logic [15:0] sweep_y [0:19] = '{
        16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000,
        16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF,
        16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };

    sixteen_bit #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .select (select),
        .a      (a),
        .b      (b),
        .Cin    (Cin),
        .y      (y),
        .Cout   (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] ey, input logic ec);
        checks++;
        assert (y === ey && Cout === ec)
        else begin
            errors++;
            $error("FAIL %s: y=%h Cout=%b, expected y=%h Cout=%b", tag, y, Cout, ey, ec);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [4:0] s, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci);
        @(negedge clk);
        select = s;
        a      = av;
        b      = bv;
        Cin    = ci;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        select = 5'b00010;
        a      = 16'h1234;
        b      = 16'h5678;
        Cin    = 1'b0;
        #3;
        check("reset_initial", 16'h0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", 16'h68AC, 1'b0);

        // Asynchronous reset between edges clears a nonzero result immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold_edge1", 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold_edge2", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply(5'(i), 16'h0000, 16'hFFFF, 1'b0);
            check($sformatf("sweep_op%0d", i), sweep_y[i], 1'b0);
        end

        apply(5'b00011, 16'hFFFF, 16'h0001, 1'b1);
        check("adc_carry", 16'h0001, 1'b1);
        apply(5'b00010, 16'hFFFF, 16'h0001, 1'b1);
        check("add_wrap", 16'h0000, 1'b1);

        apply(5'b01111, 16'h8001, 16'h0000, 1'b0);
        check("shl", 16'h0002, 1'b1);
        apply(5'b10000, 16'h8001, 16'h0000, 1'b0);
        check("shr", 16'h4000, 1'b1);
        apply(5'b10001, 16'h8001, 16'h0000, 1'b0);
        check("asr", 16'hC000, 1'b1);
        apply(5'b10010, 16'h8001, 16'h0000, 1'b0);
        check("rol", 16'h0003, 1'b1);
        apply(5'b10011, 16'h8001, 16'h0000, 1'b0);
        check("ror", 16'hC000, 1'b1);

        // Input change between edges must not reach the output until the next edge.
        apply(5'b00000, 16'hFFFF, 16'h0000, 1'b0);
        check("pass_ffff", 16'hFFFF, 1'b0);
        @(negedge clk);
        select = 5'b10111;
        #1;
        check("latency_hold", 16'hFFFF, 1'b0);
        @(posedge clk);
        #1;
        check("unused_op", 16'h0000, 1'b0);

        apply(5'b00101, 16'h0005, 16'h0003, 1'b0);
        check("sub_no_borrow", 16'h0002, 1'b1);
        apply(5'b00101, 16'h0003, 16'h0005, 1'b0);
        check("sub_borrow", 16'hFFFE, 1'b0);
        apply(5'b00100, 16'h0005, 16'h0003, 1'b0);
        check("sbb", 16'h0001, 1'b1);
        apply(5'b01010, 16'hF0F0, 16'h3C3C, 1'b1);
        check("xor_pattern", 16'hCCCC, 1'b0);

        // Reset asserted mid-cycle discards the pending result.
        @(negedge clk);
        select = 5'b00001;
        a      = 16'h7777;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_discard", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reload_after_reset", 16'h7778, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sixteen_bit.md
SIXTEEN_BIT -- requirements
Module: sixteen_bit

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; all requirements below use WIDTH=16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: select  input  5  operation code, decoded per REQ-009.
REQ-005 Port: a  input  16  operand A, unsigned.
REQ-006 Port: b  input  16  operand B, unsigned.
REQ-007 Port: Cin  input  1  carry-in, used only by opcode 00011.
REQ-008 Ports: y  output  16  registered result; Cout  output  1  registered carry/shift-out.

Function
REQ-009 The block SHALL compute (r, c) combinationally from select/a/b/Cin as follows:
- 00000 r=a, c=0
- 00001 r=a+1
- 00010 r=a+b
- 00011 r=a+b+Cin
- 00100 r=a+~b (a-b-1)
- 00101 r=a+~b+1 (a-b)
- 00110 r=a+16'hFFFF (a-1)
- 00111 r=b, c=0
- 01000 AND
- 01001 OR
- 01010 XOR
- 01011 XNOR
- 01100 r=~a
- 01101 NAND
- 01110 NOR
- 01111 logical shift left a by 1, LSB=0, c=a[15]
- 10000 logical shift right a by 1, MSB=0, c=a[0]
- 10001 arithmetic shift right a by 1, MSB=a[15], c=a[0]
- 10010 rotate left a by 1, c=a[15]
- 10011 rotate right a by 1, c=a[0]
REQ-010 For the arithmetic opcodes 00001-00110, the block SHALL set c to bit 16 of the 17-bit unsigned sum of the listed addends; subtraction c=1 means no borrow.
REQ-011 For the logic opcodes 01000-01110, the block SHALL set c=0.
REQ-012 For the unused opcodes 10100-11111, the block SHALL set r=16'h0000 and c=0.
REQ-013 On each rising clk edge with rst_n high, the block SHALL load y<=r and Cout<=c; latency is exactly 1 cycle from input change to output.
REQ-014 Arithmetic SHALL wrap modulo 2^16 with no overflow flag; e.g. FFFF+0001 gives y=0000, Cout=1.
REQ-015 The block SHALL have no handshake; every cycle produces a new result, and input changes between edges SHALL have no effect until the next edge.

Reset
REQ-016 While rst_n is low, the block SHALL force y=16'h0000 and Cout=0 immediately, independent of clk.
REQ-017 If reset is asserted mid-operation, the pending result SHALL be discarded.
REQ-018 The first rising edge after rst_n deasserts SHALL load the result for the current inputs.

Verification
REQ-019 Reset: assert rst_n=0 with a=1234, b=5678, select=00010, between edges -> y=0000, Cout=0 immediately; hold low across edges -> outputs stay 0.
REQ-020 Sweep select 00000..10011, one edge each, with a=0000, b=FFFF, Cin=0 -> bench SHALL check each op against these values:
- 00000 y=0000 C=0
- 00001 y=0001 C=0
- 00010 y=FFFF C=0
- 00011 y=FFFF C=0
- 00100 y=0000 C=0
- 00101 y=0001 C=0
- 00110 y=FFFF C=0
- 00111 y=FFFF C=0
- 01000 y=0000
- 01001 y=FFFF
- 01010 y=FFFF
- 01011 y=0000
- 01100 y=FFFF
- 01101 y=FFFF
- 01110 y=0000
- 01111 through 10011 y=0000 C=0
REQ-021 Carry: a=FFFF, b=0001, Cin=1, select=00011 -> y=0001, Cout=1; select=00010 -> y=0000, Cout=1.
REQ-022 Shift/rotate, a=8001: 01111 -> y=0002 C=1; 10000 -> y=4000 C=1; 10001 -> y=C000 C=1; 10010 -> y=0003 C=1; 10011 -> y=C000 C=1.
REQ-023 Latency/unused: changing select to 10111 with a=FFFF -> y stays at the old value until the next edge, then y=0000, Cout=0; subtraction a=0005, b=0003, select=00101 -> y=0002, Cout=1.
